branch_resolve_queue: RTL

//  Other end of the 2-bit-counter branch predictor. Fetch records each predicted

---
 rtl/branch_resolve_queue.sv | 100 ++++++++++
 1 files changed

// File: rtl/branch_resolve_queue.sv
// In-flight branch queue between fetch and execute. It checks each resolution against
// the recorded prediction, flushes and redirects on a mispredict, and trains the predictor.
module branch_resolve_queue #(
   parameter  int DEPTH = 4,
   parameter  int PC_W  = 32,
   parameter  int IDX_W = 6,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pred_valid,
   input  logic [PC_W-1:0]  pred_pc,
   input  logic             pred_taken,
   input  logic [PC_W-1:0]  pred_target,
   output logic             pred_ready,
   input  logic             res_valid,
   input  logic             res_taken,
   input  logic [PC_W-1:0]  res_target,
   output logic             mispredict,
   output logic [PC_W-1:0]  redirect_pc,
   output logic             upd_valid,
   output logic [IDX_W-1:0] upd_idx,
   output logic             upd_taken,
   output logic [CNT_W-1:0] count,
   output logic             err_underflow
);

   logic [PC_W-1:0]  pc_mem     [DEPTH];
   logic             taken_mem  [DEPTH];
   logic [PC_W-1:0]  target_mem [DEPTH];

   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [PC_W-1:0]  head_pc, head_target;
   logic             head_taken;
   logic             deq, enq, mis, flush;

   assign pred_ready  = (count != CNT_W'(DEPTH));
   assign head_pc     = pc_mem[rd_ptr];
   assign head_taken  = taken_mem[rd_ptr];
   assign head_target = target_mem[rd_ptr];

   always_comb begin
      deq   = res_valid && (count != '0);
      mis   = (res_taken != head_taken) ||
              (res_taken && head_taken && (res_target != head_target));
      flush = deq && mis;
      // Anything fetched alongside a mispredicting resolve is wrong-path, so drop it.
      enq   = pred_valid && pred_ready && !flush;
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         pc_mem[wr_ptr]     <= pred_pc;
         taken_mem[wr_ptr]  <= pred_taken;
         target_mem[wr_ptr] <= pred_target;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({enq, deq})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         upd_valid     <= 1'b0;
         mispredict    <= 1'b0;
         upd_idx       <= '0;
         upd_taken     <= 1'b0;
         redirect_pc   <= '0;
         err_underflow <= 1'b0;
      end else begin
         upd_valid  <= deq;
         mispredict <= flush;
         if (deq) begin
            upd_idx     <= head_pc[IDX_W+1:2];
            upd_taken   <= res_taken;
            redirect_pc <= res_taken ? res_target : head_pc + PC_W'(4);
         end
         if (res_valid && (count == '0)) err_underflow <= 1'b1;
      end
   end

endmodule
